hdub_core_logic_gate_sweeper: RTL and testbench

Sequential stimulus-and-check engine that sits directly around the logic gate stage. Upstream, it drives `lhs`, `rhs` and `operand` into the binary and unary gate harnesses. Downstream, it consumes `and_result`, `or_result`, `xor_result` and `not_result`. On each `start`, it sweeps all 8 input combinations, compares every gate output against the expected truth table, and reports a pass/fail summary. It is used in simulation tops and in built-in self-test of the gate library.

---
 rtl/hdub_core_logic_gate_sweeper.sv | 163 ++++++++++++++++
 tb/tb_hdub_core_logic_gate_sweeper.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdub_core_logic_gate_sweeper.sv
// hdub_core_logic_gate_sweeper
//
// Stimulus-and-check engine for the logic gate stage. Each accepted start
// steps through all 8 input vectors. Every vector is held for SETTLE_CYCLES
// cycles, then checked for one cycle. The engine checks the AND/OR/XOR/NOT
// outputs against their truth tables and accumulates a pass/fail summary.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   start, abort             begin a sweep (IDLE/DONE only), cancel a running sweep
//   lhs, rhs, operand        gate drives; {operand, lhs, rhs} is the vector index
//   and_result .. not_result gate outputs under test (combinational on the drives)
//   busy, done, pass         sweep status; pass = done with zero mismatches
//   err_count                total gate mismatches in the sweep (0..32)
//   fail_mask                sticky per-gate fail flags {NOT, XOR, OR, AND}
//   first_fail_valid/_vec    vector index of the first mismatch
module hdub_core_logic_gate_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       lhs,
  output logic       rhs,
  output logic       operand,
  input  logic       and_result,
  input  logic       or_result,
  input  logic       xor_result,
  input  logic       not_result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [3:0] fail_mask,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] settle_cnt;
  logic       accept_start;
  logic       do_abort;
  logic       do_check;
  logic [2:0] vec;
  logic [3:0] expected;
  logic [3:0] observed;
  logic [3:0] mismatch;
  logic [2:0] mismatch_count;

  // The drive registers are the vector index. This avoids a separate vec
  // register that could disagree with what the gates actually see.
  assign vec = {operand, lhs, rhs};

  // Bit order matches fail_mask: {NOT, XOR, OR, AND}.
  assign expected = {~vec[2], vec[1] ^ vec[0], vec[1] | vec[0], vec[1] & vec[0]};
  assign observed = {not_result, xor_result, or_result, and_result};
  assign mismatch = expected ^ observed;
  assign mismatch_count = {2'b00, mismatch[0]} + {2'b00, mismatch[1]}
                        + {2'b00, mismatch[2]} + {2'b00, mismatch[3]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_next   = state;
    accept_start = 1'b0;
    do_abort     = 1'b0;
    do_check     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        // abort is ignored here but still outranks a coincident start.
        if (start && !abort) begin
          accept_start = 1'b1;
          state_next   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          do_abort   = 1'b1;
          state_next = S_IDLE;
        end else if (settle_cnt == 8'd0) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        // An abort in the same cycle discards this vector's comparison.
        if (abort) begin
          do_abort   = 1'b1;
          state_next = S_IDLE;
        end else begin
          do_check   = 1'b1;
          state_next = (vec == 3'd7) ? S_DONE : S_SETTLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt       <= 8'd0;
      {operand, lhs, rhs} <= 3'b000;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 6'd0;
      fail_mask        <= 4'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
    end else if (accept_start) begin
      settle_cnt       <= SETTLE_RELOAD;
      {operand, lhs, rhs} <= 3'b000;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 6'd0;
      fail_mask        <= 4'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 3'd0;
    end else if (do_abort) begin
      // Statistics keep their partial values; only control and drives drop.
      {operand, lhs, rhs} <= 3'b000;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else if (do_check) begin
      err_count <= err_count + 6'(mismatch_count);
      fail_mask <= fail_mask | mismatch;
      if (mismatch != 4'd0 && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= vec;
      end
      if (vec == 3'd7) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 6'd0) && (mismatch == 4'd0);
      end else begin
        {operand, lhs, rhs} <= vec + 3'd1;
        settle_cnt          <= SETTLE_RELOAD;
      end
    end else if (state == S_SETTLE && settle_cnt != 8'd0) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_hdub_core_logic_gate_sweeper.sv
// Testbench for hdub_core_logic_gate_sweeper.
// Two instances: index 0 with SETTLE_CYCLES=1, index 1 with SETTLE_CYCLES=3.
// A behavioural gate harness sits around each instance. It can inject faults:
//   mode 0 correct, 1 AND stuck-at-0, 2 NOT as buffer plus XOR built as OR,
//   3 OR stuck-at-1, 4 random per-vector flip table.
// The expected statistics come from truth tables written in plain arithmetic.
module tb_hdub_core_logic_gate_sweeper;

  typedef struct packed {
    logic       ffv;
    logic [2:0] ffvec;
    logic [3:0] mask;
    logic [5:0] err;
  } stats_t;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic abort [2];
  logic lhs [2];
  logic rhs [2];
  logic operand [2];
  logic and_r [2];
  logic or_r [2];
  logic xor_r [2];
  logic not_r [2];
  logic busy [2];
  logic done [2];
  logic pass [2];
  logic [5:0] err_count [2];
  logic [3:0] fail_mask [2];
  logic ffv [2];
  logic [2:0] ffvec [2];
  int          fmode [2];
  logic [31:0] flip [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hdub_core_logic_gate_sweeper #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .lhs(lhs[0]), .rhs(rhs[0]), .operand(operand[0]),
    .and_result(and_r[0]), .or_result(or_r[0]), .xor_result(xor_r[0]), .not_result(not_r[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_mask(fail_mask[0]), .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0])
  );

  hdub_core_logic_gate_sweeper #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .lhs(lhs[1]), .rhs(rhs[1]), .operand(operand[1]),
    .and_result(and_r[1]), .or_result(or_r[1]), .xor_result(xor_r[1]), .not_result(not_r[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_mask(fail_mask[1]), .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1])
  );

  // Gate library under test, with optional faults. Returns {NOT, XOR, OR, AND}.
  function automatic logic [3:0] gate_out(input int mode, input logic [2:0] v, input logic [31:0] fl);
    logic a, o, x, n;
    a = v[1] & v[0];
    o = v[1] | v[0];
    x = v[1] ^ v[0];
    n = ~v[2];
    case (mode)
      1: a = 1'b0;
      2: begin n = v[2]; x = v[1] | v[0]; end
      3: o = 1'b1;
      default: ;
    endcase
    gate_out = {n, x, o, a};
    if (mode == 4) gate_out = gate_out ^ fl[4*v +: 4];
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] r;
      r = gate_out(fmode[d], {operand[d], lhs[d], rhs[d]}, flip[d]);
      and_r[d] = r[0];
      or_r[d]  = r[1];
      xor_r[d] = r[2];
      not_r[d] = r[3];
    end
  end

  // Reference statistics after the first nv vectors of a sweep.
  function automatic stats_t model(input int mode, input logic [31:0] fl, input int nv);
    stats_t s;
    s = '0;
    for (int v = 0; v < nv; v++) begin
      int r, l, o;
      logic [3:0] truth, diff;
      r = v % 2;
      l = (v / 2) % 2;
      o = (v / 4) % 2;
      truth[0] = (l * r) != 0;
      truth[1] = (l + r) > 0;
      truth[2] = ((l + r) % 2) != 0;
      truth[3] = (1 - o) != 0;
      diff = truth ^ gate_out(mode, 3'(v), fl);
      for (int g = 0; g < 4; g++) begin
        if (diff[g]) begin
          s.err = s.err + 6'd1;
          s.mask[g] = 1'b1;
          if (!s.ffv) begin
            s.ffv = 1'b1;
            s.ffvec = 3'(v);
          end
        end
      end
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] outs(input int d);
    return {lhs[d], rhs[d], operand[d], busy[d], done[d], pass[d],
            err_count[d], fail_mask[d], ffv[d], ffvec[d]};
  endfunction

  function automatic logic [2:0] vec_of(input int d);
    return {operand[d], lhs[d], rhs[d]};
  endfunction

  task automatic check_stats(input string tag, input int d, input stats_t m);
    check({tag, "_err"}, err_count[d], m.err);
    check({tag, "_mask"}, fail_mask[d], m.mask);
    check({tag, "_ffv"}, ffv[d], m.ffv);
    check({tag, "_ffvec"}, ffvec[d], m.ffvec);
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  // Full sweep: checks start-to-done latency and the final statistics.
  task automatic sweep(input int d, input int mode, input int lat);
    stats_t m;
    int n;
    fmode[d] = mode;
    pulse_start(d);
    check("busy_rise", busy[d], 1);
    n = 0;
    while (!done[d] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, lat);
    @(negedge clk);
    m = model(mode, flip[d], 8);
    check("busy_fall", busy[d], 0);
    check("pass", pass[d], (m.err == 0) ? 1 : 0);
    check_stats("sweep", d, m);
  endtask

  // Start a sweep on instance 0 and run until the drives show target_vec.
  task automatic run_to_vec(input int mode, input logic [2:0] target_vec, output int n);
    fmode[0] = mode;
    pulse_start(0);
    n = 0;
    while (vec_of(0) != target_vec && n < 100) begin
      @(negedge clk);
      if (n == 3) start[0] = 1'b1;  // must be ignored while busy
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      n++;
    end
  endtask

  task automatic do_abort(input int d);
    @(negedge clk);
    abort[d] = 1'b1;
    @(posedge clk);
    #1;
    abort[d] = 1'b0;
  endtask

  initial begin
    stats_t m;
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      abort[d] = 1'b0;
      fmode[d] = 0;
      flip[d]  = '0;
    end
    #1;
    check("reset_outs0", outs(0), 0);
    check("reset_outs1", outs(1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct gates, then the two fixed fault scenarios.
    sweep(0, 0, 16);
    sweep(0, 1, 16);
    check("and_stuck_err", err_count[0], 2);
    check("and_stuck_mask", fail_mask[0], 4'b0001);
    check("and_stuck_ffvec", ffvec[0], 3);
    sweep(0, 2, 16);
    check("not_xor_mask", fail_mask[0], 4'b1100);
    check("not_xor_ffvec", ffvec[0], 0);

    // Start while busy is ignored: vec 4 appears exactly 8 edges after start.
    run_to_vec(1, 3'd4, n);
    check("busy_start_ignored", n, 8);
    do_abort(0);
    check("abort_busy", busy[0], 0);
    check("abort_done", done[0], 0);
    check("abort_drives", vec_of(0), 0);
    check_stats("abort_partial", 0, model(1, '0, 4));
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", {busy[0], done[0], vec_of(0)}, 0);

    // Abort coincident with the CHECK of vec 7 discards that comparison.
    run_to_vec(2, 3'd7, n);
    @(posedge clk);
    #1;
    do_abort(0);
    check("abort_check_busy", busy[0], 0);
    check_stats("abort_check", 0, model(2, '0, 7));

    // Asynchronous reset between edges, mid-sweep at vec 5.
    run_to_vec(0, 3'd5, n);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs0", outs(0), 0);
    check("async_rst_outs1", outs(1), 0);
    #1;
    rst = 1'b0;
    sweep(0, 0, 16);

    // Long settle: faulty OR, then a clean restart from DONE.
    sweep(1, 3, 32);
    check("or_fault_pass", pass[1], 0);
    sweep(1, 0, 32);
    check("restart_pass", pass[1], 1);

    // Random fault tables on both instances.
    for (int i = 0; i < 8; i++) begin
      int d;
      d = i % 2;
      for (int v = 0; v < 8; v++)
        flip[d][4*v +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      sweep(d, 4, d ? 32 : 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
